// File: rtl/vga_draw_scheduler.sv
// Purpose : sole owner of the vga_adapter pixel-write port; sequences full-screen
//           clears (priority) and 16x16 sprite blits read from the graphics ROM.
// Latency : clear pixel n plots 2+n cycles after clear_req is seen; sprite pixel k
//           plots 3+k cycles after the draw handshake (ROM adds one cycle).
// Backpressure: draw_ready is low whenever busy or clear_req is high; clear_req
//           is a level, ignored while a clear is already running.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   clear_req             level request for a full-screen clear
//   draw_valid/draw_ready sprite request handshake, with draw_x/draw_y/draw_id
//   rom_addr/rom_q        {id,row,col} to the 1-cycle-latency sprite ROM, data back
//   vga_x/y/colour/plot   pixel-write port of vga_adapter
//   busy                  high while clearing or drawing
//   clear_done/draw_done  single-cycle completion pulses
module vga_draw_scheduler #(
  parameter int          SCREEN_W     = 320,
  parameter int          SCREEN_H     = 240,
  parameter int          SPRITE_SZ    = 16,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
  parameter bit          KEY_EN       = 1'b0,
  parameter logic [2:0]  KEY_COLOUR   = 3'b101,
  localparam int         SB           = $clog2(SPRITE_SZ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              draw_valid,
  output logic              draw_ready,
  input  logic [8:0]        draw_x,
  input  logic [7:0]        draw_y,
  input  logic [1:0]        draw_id,
  output logic [2*SB+1:0]   rom_addr,
  input  logic [2:0]        rom_q,
  output logic [8:0]        vga_x,
  output logic [7:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              busy,
  output logic              clear_done,
  output logic              draw_done
);

  localparam logic [8:0]      X_MAX  = 9'(SCREEN_W - SPRITE_SZ);
  localparam logic [7:0]      Y_MAX  = 8'(SCREEN_H - SPRITE_SZ);
  localparam logic [8:0]      X_LAST = 9'(SCREEN_W - 1);
  localparam logic [7:0]      Y_LAST = 8'(SCREEN_H - 1);
  localparam logic [2*SB-1:0] K_LAST = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DRAIN} state_t;

  state_t     state;
  logic [8:0] x0;
  logic [7:0] y0;
  // Address stage: rom_addr holds a live sprite pixel this cycle.
  logic       a_vld;
  // Data stage: rom_q belongs to the pixel whose screen coordinates are q_x/q_y.
  logic       q_vld;
  logic [8:0] q_x;
  logic [7:0] q_y;
  // Clear scan position; clr_end marks the trailing cycle after the last pixel.
  logic [8:0] cx;
  logic [7:0] cy;
  logic       clr_end;
  logic       keyed;

  assign draw_ready = reset & (state == IDLE) & ~clear_req;
  assign keyed      = KEY_EN && (rom_q == KEY_COLOUR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      x0         <= '0;
      y0         <= '0;
      a_vld      <= 1'b0;
      q_vld      <= 1'b0;
      q_x        <= '0;
      q_y        <= '0;
      cx         <= '0;
      cy         <= '0;
      clr_end    <= 1'b0;
      rom_addr   <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      draw_done  <= 1'b0;
    end else begin
      vga_plot   <= 1'b0;
      clear_done <= 1'b0;
      draw_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            cx      <= '0;
            cy      <= '0;
            clr_end <= 1'b0;
          end else if (draw_valid) begin
            // Clamp so the whole sprite always lands on screen: no clipping, no wrap.
            x0       <= (draw_x > X_MAX) ? X_MAX : draw_x;
            y0       <= (draw_y > Y_MAX) ? Y_MAX : draw_y;
            rom_addr <= {draw_id, {(2*SB){1'b0}}};
            a_vld    <= 1'b1;
            state    <= DRAW;
            busy     <= 1'b1;
          end
        end

        CLEAR: begin
          if (clr_end) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            vga_x      <= cx;
            vga_y      <= cy;
            vga_colour <= CLEAR_COLOUR;
            vga_plot   <= 1'b1;
            if (cx == X_LAST) begin
              cx <= '0;
              if (cy == Y_LAST) clr_end <= 1'b1;
              else              cy      <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
        end

        DRAW, DRAIN: begin
          if (clear_req) begin
            // Abort: drop everything still in the ROM pipeline, no draw_done.
            state   <= CLEAR;
            a_vld   <= 1'b0;
            q_vld   <= 1'b0;
            cx      <= '0;
            cy      <= '0;
            clr_end <= 1'b0;
          end else begin
            q_vld <= a_vld;
            q_x   <= x0 + 9'(rom_addr[SB-1:0]);
            q_y   <= y0 + 8'(rom_addr[2*SB-1:SB]);
            // Keyed pixels leave the port untouched so it holds its last value.
            if (q_vld && !keyed) begin
              vga_x      <= q_x;
              vga_y      <= q_y;
              vga_colour <= rom_q;
              vga_plot   <= 1'b1;
            end
            if (state == DRAW) begin
              if (rom_addr[2*SB-1:0] == K_LAST) begin
                a_vld <= 1'b0;
                state <= DRAIN;
              end else begin
                rom_addr[2*SB-1:0] <= rom_addr[2*SB-1:0] + 1'b1;
              end
            end else if (!q_vld) begin
              // Last pixel has left the data stage.
              state     <= IDLE;
              busy      <= 1'b0;
              draw_done <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
module tb_vga_draw_scheduler;

  localparam logic [2:0] KEY = 3'b101;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear_req = 1'b0;
  logic       draw_valid = 1'b0;
  logic [8:0] draw_x = '0;
  logic [7:0] draw_y = '0;
  logic [1:0] draw_id = '0;

  logic       draw_ready, k_draw_ready;
  logic [9:0] rom_addr, k_rom_addr;
  logic [2:0] rom_q, k_rom_q;
  logic [8:0] vga_x, k_vga_x;
  logic [7:0] vga_y, k_vga_y;
  logic [2:0] vga_colour, k_vga_colour;
  logic       vga_plot, k_vga_plot;
  logic       busy, k_busy;
  logic       clear_done, k_clear_done;
  logic       draw_done, k_draw_done;

  logic [2:0] rom_mem [1024];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  vga_draw_scheduler dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .draw_valid(draw_valid), .draw_ready(draw_ready),
    .draw_x(draw_x), .draw_y(draw_y), .draw_id(draw_id),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .clear_done(clear_done), .draw_done(draw_done)
  );

  vga_draw_scheduler #(.KEY_EN(1'b1), .KEY_COLOUR(KEY)) dut_key (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .draw_valid(draw_valid), .draw_ready(k_draw_ready),
    .draw_x(draw_x), .draw_y(draw_y), .draw_id(draw_id),
    .rom_addr(k_rom_addr), .rom_q(k_rom_q),
    .vga_x(k_vga_x), .vga_y(k_vga_y), .vga_colour(k_vga_colour), .vga_plot(k_vga_plot),
    .busy(k_busy), .clear_done(k_clear_done), .draw_done(k_draw_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM models (one per instance) and a free-running cycle index.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rom_q   <= rom_mem[rom_addr];
    k_rom_q <= rom_mem[k_rom_addr];
  end

  function automatic int clampv(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vga_x, vga_y, vga_colour, rom_addr} !== 30'd0) begin
      errors++; $display("FAIL reset_regs: got %h want 0", {vga_x, vga_y, vga_colour, rom_addr});
    end
    checks++;
    if ({vga_plot, busy, clear_done, draw_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {vga_plot, busy, clear_done, draw_done});
    end
    checks++;
    if (draw_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", draw_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({draw_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL reset_release: ready,busy got %b want 10", {draw_ready, busy});
    end
  endtask

  // Clear and draw requested together: clear wins, draw is taken once idle again.
  task automatic test_clear_then_draw();
    int c, t, n, bad, nplot, done_t, first_t, tt, dplots, dfirst, ddone;
    logic [16:0] last_xy;
    logic [16:0] dfirst_xy;
    logic [2:0]  dfirst_col;
    @(negedge clk);
    c = cyc;
    clear_req = 1'b1; draw_valid = 1'b1;
    draw_x = 9'd50; draw_y = 8'd60; draw_id = 2'd1;
    #1;
    checks++;
    if (draw_ready !== 1'b0) begin
      errors++; $display("FAIL clear_wins_ready: got %b want 0", draw_ready);
    end
    @(negedge clk);
    clear_req = 1'b0;
    bad = 0; nplot = 0; done_t = -1; first_t = -1; last_xy = '0;
    for (int i = 0; i < 76810 && done_t < 0; i++) begin
      t = cyc - c;
      n = t - 2;
      if (t >= 2 && t <= 76801) begin
        if (vga_plot !== 1'b1 || vga_x !== 9'(n % 320) || vga_y !== 8'(n / 320) || vga_colour !== 3'd0)
          bad++;
        if (busy !== 1'b1 || draw_ready !== 1'b0) bad++;
      end else if (t < 76802) begin
        if (vga_plot !== 1'b0) bad++;
      end
      if (vga_plot === 1'b1) begin
        nplot++;
        if (first_t < 0) first_t = t;
        last_xy = {vga_x, vga_y};
      end
      if (clear_done === 1'b1) done_t = t;
      else @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_pixels: %0d bad cycles, want 0", bad); end
    checks++;
    if (nplot != 76800) begin errors++; $display("FAIL clear_count: got %0d want 76800", nplot); end
    checks++;
    if (first_t != 2) begin errors++; $display("FAIL clear_first: at C+%0d want C+2", first_t); end
    checks++;
    if (last_xy !== {9'd319, 8'd239}) begin
      errors++; $display("FAIL clear_last: got (%0d,%0d) want (319,239)", last_xy[16:8], last_xy[7:0]);
    end
    checks++;
    if (done_t != 76802) begin errors++; $display("FAIL clear_done_time: C+%0d want C+76802", done_t); end
    // The held draw request is accepted in the cycle clear_done pulses.
    checks++;
    if (draw_ready !== 1'b1) begin errors++; $display("FAIL draw_after_clear_ready: got %b want 1", draw_ready); end
    tt = cyc;
    @(negedge clk);
    draw_valid = 1'b0;
    dplots = 0; dfirst = -1; ddone = -1; dfirst_xy = '0; dfirst_col = '0;
    for (int i = 0; i < 262; i++) begin
      t = cyc - tt;
      if (vga_plot === 1'b1) begin
        dplots++;
        if (dfirst < 0) begin dfirst = t; dfirst_xy = {vga_x, vga_y}; dfirst_col = vga_colour; end
      end
      if (draw_done === 1'b1 && ddone < 0) ddone = t;
      @(negedge clk);
    end
    checks++;
    if (dfirst != 3 || dfirst_xy !== {9'd50, 8'd60} || dfirst_col !== rom_mem[10'd256]) begin
      errors++;
      $display("FAIL draw_after_clear_first: T+%0d (%0d,%0d) c%0d want T+3 (50,60) c%0d",
               dfirst, dfirst_xy[16:8], dfirst_xy[7:0], dfirst_col, rom_mem[10'd256]);
    end
    checks++;
    if (dplots != 256 || ddone != 259) begin
      errors++; $display("FAIL draw_after_clear_end: plots %0d done T+%0d want 256, T+259", dplots, ddone);
    end
  endtask

  // Sprite draws against a pixel-list model; the keyed instance runs the same stimulus.
  task automatic test_draw();
    int x, y, id, x0, y0, tt, k, ex, ey, bad, nplot, kplot, exp_kplot, ndone, done_t, kdone_t, oob;
    logic [2:0]  ec;
    logic [16:0] last_xy;
    for (int d = 0; d < 5; d++) begin
      if (d == 0)      begin x = 10;  y = 20;  id = 2; end
      else if (d == 1) begin x = 310; y = 230; id = 3; end
      else begin
        x = int'($urandom_range(0, 511)); y = int'($urandom_range(0, 255)); id = int'($urandom_range(0, 3));
      end
      x0 = clampv(x, 304); y0 = clampv(y, 224);
      @(negedge clk);
      tt = cyc;
      draw_valid = 1'b1; draw_x = 9'(x); draw_y = 8'(y); draw_id = 2'(id);
      #1;
      checks++;
      if (draw_ready !== 1'b1) begin errors++; $display("FAIL draw%0d_ready: got %b want 1", d, draw_ready); end
      @(negedge clk);
      draw_valid = 1'b0;
      bad = 0; nplot = 0; kplot = 0; exp_kplot = 0; ndone = 0; done_t = -1; kdone_t = -1; oob = 0;
      last_xy = '0;
      for (int i = 0; i < 262; i++) begin
        int t;
        t = cyc - tt;
        k = t - 3;
        if (k >= 0 && k < 256) begin
          ex = x0 + k % 16; ey = y0 + k / 16; ec = rom_mem[id * 256 + k];
          if (vga_plot !== 1'b1 || vga_x !== 9'(ex) || vga_y !== 8'(ey) || vga_colour !== ec) bad++;
          if (ec != KEY) begin
            exp_kplot++;
            if (k_vga_plot !== 1'b1 || k_vga_x !== 9'(ex) || k_vga_y !== 8'(ey) || k_vga_colour !== ec) bad++;
          end else if (k_vga_plot !== 1'b0) bad++;
        end else if (vga_plot !== 1'b0 || k_vga_plot !== 1'b0) bad++;
        if (busy !== (t <= 258)) bad++;
        if (vga_plot === 1'b1) begin
          nplot++;
          last_xy = {vga_x, vga_y};
          if (vga_x > 9'd319 || vga_y > 8'd239) oob++;
        end
        if (k_vga_plot === 1'b1) kplot++;
        if (draw_done === 1'b1) begin ndone++; if (done_t < 0) done_t = t; end
        if (k_draw_done === 1'b1 && kdone_t < 0) kdone_t = t;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL draw%0d_pixels: %0d bad cycles, want 0", d, bad); end
      checks++;
      if (nplot != 256 || oob != 0) begin
        errors++; $display("FAIL draw%0d_count: plots %0d offscreen %0d want 256, 0", d, nplot, oob);
      end
      checks++;
      if (last_xy !== {9'(x0 + 15), 8'(y0 + 15)}) begin
        errors++;
        $display("FAIL draw%0d_last: got (%0d,%0d) want (%0d,%0d)", d, last_xy[16:8], last_xy[7:0], x0 + 15, y0 + 15);
      end
      checks++;
      if (done_t != 259 || ndone != 1) begin
        errors++; $display("FAIL draw%0d_done: T+%0d x%0d want T+259 x1", d, done_t, ndone);
      end
      checks++;
      if (kplot != exp_kplot || kdone_t != 259) begin
        errors++; $display("FAIL draw%0d_keyed: plots %0d done T+%0d want %0d, T+259", d, kplot, kdone_t, exp_kplot);
      end
    end
  endtask

  // Clear interrupts a sprite, then reset lands in the middle of that clear.
  task automatic test_abort_and_reset();
    int tt, t, k, n, bad, ndone;
    logic first_clear_ok;
    @(negedge clk);
    tt = cyc;
    draw_valid = 1'b1; draw_x = 9'd100; draw_y = 8'd50; draw_id = 2'd1;
    @(negedge clk);
    draw_valid = 1'b0;
    bad = 0; ndone = 0; first_clear_ok = 1'b0;
    for (int i = 0; i < 602; i++) begin
      t = cyc - tt;
      k = t - 3;
      n = t - 102;
      if (t >= 3 && t <= 100) begin
        if (vga_plot !== 1'b1 || vga_x !== 9'(100 + k % 16) || vga_y !== 8'(50 + k / 16) ||
            vga_colour !== rom_mem[256 + k]) bad++;
      end else if (t >= 102) begin
        if (vga_plot !== 1'b1 || vga_x !== 9'(n % 320) || vga_y !== 8'(n / 320) || vga_colour !== 3'd0) bad++;
      end else if (vga_plot !== 1'b0) bad++;
      if (t == 102) first_clear_ok = (vga_plot === 1'b1) && (vga_x === 9'd0) && (vga_y === 8'd0);
      if (draw_done === 1'b1) ndone++;
      clear_req = (t == 100);
      reset = (t != 602);
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_pixels: %0d bad cycles, want 0", bad); end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    checks++;
    if (first_clear_ok !== 1'b1) begin errors++; $display("FAIL abort_clear_start: got %b want 1", first_clear_ok); end
    checks++;
    if ({vga_plot, busy, vga_x, vga_y, vga_colour, rom_addr} !== 32'd0) begin
      errors++;
      $display("FAIL midclear_reset: plot %b busy %b x %0d y %0d want all 0", vga_plot, busy, vga_x, vga_y);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({draw_ready, busy, vga_plot} !== 3'b100) begin
      errors++; $display("FAIL after_reset_idle: ready,busy,plot got %b want 100", {draw_ready, busy, vga_plot});
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++)
      rom_mem[a] = (a / 256 == 2) ? 3'(a) : 3'($urandom_range(0, 7));
    test_reset();
    test_clear_then_draw();
    test_draw();
    test_abort_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
